// File: rtl/restoring_divider_pkg.sv
// Shared types and constants for the restoring divider and its trial subtractor.
package restoring_divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

  function automatic int step_cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Combinational a - b as a + ~b + 1 using flat generate/propagate carry look-ahead.
module cla_subtractor
  import restoring_divider_pkg::*;
#(
  parameter int N = DIV_WIDTH + 1
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow_n
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & ~b;
  assign p = a ^ ~b;

  // Each carry is a sum of products of g/p terms and the carry-in, with no rippling between bits.
  always_comb begin
    logic prod;
    c    = '0;
    prod = 1'b0;
    c[0] = 1'b1;
    for (int i = 0; i < N; i++) begin
      c[i+1] = g[i];
      prod   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prod & g[j]);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | prod;
    end
  end

  assign diff     = p ^ c[N-1:0];
  assign borrow_n = c[N];

endmodule

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock with start/busy/done handshake.
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = step_cnt_w(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   rs;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   r_step;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q_step;
  logic             borrow_n;
  logic             fits;
  logic             last;
  logic             accept;

  assign rs = {r[WIDTH-1:0], q[WIDTH-1]};

  cla_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a       (rs),
    .b       ({1'b0, d}),
    .diff    (diff),
    .borrow_n(borrow_n)
  );

  // R < D holds between steps, so all three terms agree; requiring them together rejects a disturbed R.
  assign fits   = borrow_n & ~diff[WIDTH] & ~r[WIDTH];
  assign r_step = fits ? diff : rs;
  assign q_step = {q[WIDTH-2:0], fits};
  assign last   = (cnt == CNT_W'(WIDTH - 1));
  assign accept = start && (state != RUN);

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (divisor == '0) ? DONE : RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    state_next = start ? ((divisor == '0) ? DONE : RUN) : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, per-step shift/subtract, and result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      r   <= '0;
      q   <= dividend;
      d   <= divisor;
      cnt <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      r   <= r_step;
      q   <= q_step;
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient  <= q_step;
        remainder <= r_step[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Bench for restoring_divider: directed cases plus a random sweep against an arithmetic reference model.
module tb_restoring_divider;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  always #5 clk = ~clk;

  restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: counts down the busy window and releases a precomputed a/b, a%b when it expires.
  int           m_left = 0;
  logic         m_done = 1'b0;
  logic         m_dbz = 1'b0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic [W-1:0] p_q = '0;
  logic [W-1:0] p_r = '0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  int           accepts = 0;
  int           aborted = 0;
  int           dones_seen = 0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      if (m_left > 0) aborted <= aborted + 1;
      m_left <= 0;
      m_done <= 1'b0;
      m_dbz  <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
        end
      end else if (start) begin
        accepts <= accepts + 1;
        m_a     <= dividend;
        m_b     <= divisor;
        if (divisor == '0) begin
          m_q    <= '1;
          m_r    <= dividend;
          m_dbz  <= 1'b1;
          m_done <= 1'b1;
        end else begin
          p_q    <= dividend / divisor;
          p_r    <= dividend % divisor;
          m_q    <= '0;
          m_r    <= '0;
          m_dbz  <= 1'b0;
          m_left <= W;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic exp_busy;
      exp_busy = (m_left > 0);
      tests++;
      if ({busy, done, div_by_zero, quotient, remainder} !== {exp_busy, m_done, m_dbz, m_q, m_r}) begin
        fails++;
        $display("FAIL cycle_compare t=%0t busy/done/dbz/q/r got %b/%b/%b/%0d/%0d want %b/%b/%b/%0d/%0d",
                 $time, busy, done, div_by_zero, quotient, remainder,
                 exp_busy, m_done, m_dbz, m_q, m_r);
      end
      if (done === 1'b1) begin
        dones_seen++;
        if (div_by_zero === 1'b0) begin
          tests++;
          if ((int'(quotient) * int'(m_b) + int'(remainder) != int'(m_a)) || (remainder >= m_b)) begin
            fails++;
            $display("FAIL identity a=%0d b=%0d got q=%0d r=%0d", m_a, m_b, quotient, remainder);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom_range(0, 255));
    divisor  = W'($urandom_range(0, 255));
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 3 * W) begin
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL done_timeout got no done after %0d cycles want done", lat);
    end
  endtask

  int ta[4] = '{255, 7, 0, 255};
  int tb[4] = '{1, 9, 5, 255};
  int tq[4] = '{255, 0, 0, 1};
  int tr[4] = '{0, 7, 0, 0};

  initial begin
    int lat;
    int dones_before;
    int a;
    int b;

    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_quotient", quotient, 0);
    check("reset_busy", busy, 0);
    check("reset_dbz", div_by_zero, 0);

    do_start(8'd150, 8'd32);
    check("busy_after_accept", busy, 1);
    wait_done(lat);
    check("latency_150_32", lat, W);
    check("q_150_32", quotient, 4);
    check("r_150_32", remainder, 22);
    check("dbz_150_32", div_by_zero, 0);

    for (int i = 0; i < 4; i++) begin
      do_start(W'(ta[i]), W'(tb[i]));
      check("b2b_busy_no_gap", busy, 1);
      wait_done(lat);
      check("b2b_latency", lat, W);
      check("b2b_quotient", quotient, tq[i]);
      check("b2b_remainder", remainder, tr[i]);
    end

    @(negedge clk);
    do_start(8'd100, 8'd0);
    check("dz_done_next_cycle", done, 1);
    check("dz_busy", busy, 0);
    check("dz_quotient", quotient, 255);
    check("dz_remainder", remainder, 100);
    check("dz_flag", div_by_zero, 1);
    @(negedge clk);
    check("dz_done_single_pulse", done, 0);
    do_start(8'd10, 8'd3);
    check("dz_cleared_on_start", div_by_zero, 0);
    wait_done(lat);
    check("q_10_3", quotient, 3);
    check("r_10_3", remainder, 1);

    @(negedge clk);
    do_start(8'd200, 8'd7);
    repeat (2) @(negedge clk);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_done(lat);
    check("ignored_start_q", quotient, 28);
    check("ignored_start_r", remainder, 4);
    repeat (3) @(negedge clk);
    check("hold_q", quotient, 28);
    check("hold_r", remainder, 4);
    check("hold_done", done, 0);

    do_start(8'd200, 8'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrun_reset_q", quotient, 0);
    check("midrun_reset_r", remainder, 0);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_done", done, 0);
    dones_before = dones_seen;
    repeat (W + 2) @(negedge clk);
    check("midrun_reset_no_done", dones_seen, dones_before);
    do_start(8'd9, 8'd4);
    wait_done(lat);
    check("q_9_4", quotient, 2);
    check("r_9_4", remainder, 1);

    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
      do_start(W'(a), W'(b));
      if (b != 0 && $urandom_range(0, 3) == 0) begin
        start    = 1'b1;
        dividend = W'($urandom_range(0, 255));
        divisor  = W'($urandom_range(0, 255));
        @(negedge clk);
        start = 1'b0;
      end
      wait_done(lat);
      check("rand_quotient", quotient, (b == 0) ? 255 : a / b);
      check("rand_remainder", remainder, (b == 0) ? a : a % b);
    end

    repeat (2) @(negedge clk);
    check("done_per_accept", dones_seen, accepts - aborted);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
